// File: rtl/fetch_queue_pkg.sv
// Shared constants for the fetch/decode decoupling queue: word width,
// the all-zero word driven on idle outputs, and the default queue depth.
package fetch_queue_pkg;

  localparam int WORD_WIDTH        = 32;
  localparam int FETCH_QUEUE_DEPTH = 4;

  localparam logic [WORD_WIDTH-1:0] ZERO_WORD = '0;

endpackage : fetch_queue_pkg

// File: rtl/fetch_queue_mem.sv
// Entry storage for fetch_queue: DEPTH x (2W) register array with one
// synchronous write port and one asynchronous read port.
module fetch_queue_mem #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [2*W-1:0]  wdata,
  input  logic [AW-1:0]   raddr,
  output logic [2*W-1:0]  rdata
);

  logic [2*W-1:0] mem [DEPTH];

  // NOTE: the array is deliberately not reset; valid data is tracked by the
  // pointers and count, so clearing it would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule : fetch_queue_mem

// File: rtl/fetch_queue.sv
// In-order (pc, inst) queue between fetch and decode with flush support.
// Define FETCH_QUEUE_BYPASS_EN to forward fetch straight to decode when empty.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int W     = WORD_WIDTH,
  parameter int DEPTH = FETCH_QUEUE_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             in_pc,
  input  logic [W-1:0]             in_inst,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W-1:0]             out_pc,
  output logic [W-1:0]             out_inst,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [2*W-1:0] rd_data;
  logic           empty;
  logic           full;
  logic           bypass;
  logic           bypass_take;
  logic           push;
  logic           pop;
  logic           wr_en;
  logic           rd_adv;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // Ready depends only on occupancy, so a pop never opens a slot in the same cycle.
  assign in_ready = ~full;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = empty & in_valid & ~flush;
`else
  assign bypass = 1'b0;
`endif

  assign out_valid   = ~empty | bypass;
  assign push        = in_valid & in_ready & ~flush;
  assign pop         = out_valid & out_ready & ~flush;
  // A bypassed pair consumed in its arrival cycle never touches storage.
  assign bypass_take = bypass & out_ready;
  assign wr_en       = push & ~bypass_take;
  assign rd_adv      = pop & ~bypass_take;

  fetch_queue_mem #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata ({in_pc, in_inst}),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    out_pc   = W'(ZERO_WORD);
    out_inst = W'(ZERO_WORD);
    if (bypass) begin
      out_pc   = in_pc;
      out_inst = in_inst;
    end else if (!empty) begin
      {out_pc, out_inst} = rd_data;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
      if (rd_adv) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(wr_en) - CW'(rd_adv);
    end
  end

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: stimulus pushes expected pairs into a
// scoreboard queue, a separate monitor checks every pop against it.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int W     = 32;
  localparam int DEPTH = 4;

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } pair_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [W-1:0]           in_pc;
  logic [W-1:0]           in_inst;
  logic                   out_valid;
  logic                   out_ready;
  logic [W-1:0]           out_pc;
  logic [W-1:0]           out_inst;
  logic [$clog2(DEPTH):0] count;

  pair_t sb[$];
  int    mcount = 0;
  int    errors = 0;
  int    checks = 0;

  fetch_queue #(.W(W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, check pre-edge outputs just before posedge.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                      input logic ordy, input logic fl);
    bit exp_ov;
    bit p;
    bit q;
    @(negedge clk);
    in_valid  = v;
    in_pc     = pc;
    in_inst   = inst;
    out_ready = ordy;
    flush     = fl;
    p = v && (mcount != DEPTH) && !fl;
    if (fl) sb.delete();
    else if (p) sb.push_back('{pc: pc, inst: inst});
    #4;
    exp_ov = (mcount != 0) || (BYP && v && !fl);
    check("count", 32'(count), mcount);
    check("in_ready", 32'(in_ready), 32'(mcount != DEPTH));
    check("out_valid", 32'(out_valid), 32'(exp_ov));
    if (!exp_ov) begin
      check("idle_pc_zero", out_pc, 32'h0);
      check("idle_inst_zero", out_inst, 32'h0);
    end
    q = exp_ov && ordy && !fl;
    if (fl) mcount = 0;
    else mcount = mcount + int'(p) - int'(q);
  endtask

  task automatic push_n(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++)
      step(1'b1, base + 32'(i * 4), 32'h2400_0000 | (base + 32'(i * 4)), 1'b0, 1'b0);
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  // Monitor: every accepted pop must match the oldest expected pair.
  initial begin
    pair_t e;
    forever begin
      @(negedge clk);
      #4;
      if (rst && out_valid && out_ready && !flush) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected: got pc 0x%0h expected no pop", out_pc);
        end else begin
          e = sb.pop_front();
          check("pop_pc", out_pc, e.pc);
          check("pop_inst", out_inst, e.inst);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_inst = '0;
    #1;
    check("rst_count", 32'(count), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_inst", out_inst, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Single push, visible next cycle, then popped.
    step(1'b1, 32'h0, 32'h2401_0005, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    pop_n(1);

    // Fill to DEPTH, rejected fifth push, drain in order.
    push_n(4, 32'h0);
    step(1'b1, 32'h10, 32'h2400_0010, 1'b0, 1'b0);
    pop_n(4);

    // Streaming ten pairs with simultaneous push and pop; pointers wrap.
    for (int i = 0; i < 10; i++)
      step(1'b1, 32'(i * 4), 32'h3400_0000 | 32'(i), 1'b1, 1'b0);
    pop_n(2);

    // Flush at count=3 alongside push and pop; next push becomes the head.
    push_n(3, 32'h40);
    step(1'b1, 32'h80, 32'h2400_0080, 1'b1, 1'b1);
    step(1'b1, 32'h100, 32'h2400_0100, 1'b0, 1'b0);
    pop_n(2);

    // Full with pop and push offered: pop only, count drops to 3.
    push_n(4, 32'h200);
    step(1'b1, 32'h300, 32'h2400_0300, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    pop_n(4);

    // Asynchronous reset between edges at count=2.
    push_n(2, 32'h400);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("arst_count", 32'(count), 32'h0);
    check("arst_out_valid", 32'(out_valid), 32'h0);
    check("arst_out_pc", out_pc, 32'h0);
    check("arst_out_inst", out_inst, 32'h0);
    check("arst_in_ready", 32'(in_ready), 32'h1);
    mcount = 0;
    sb.delete();
    @(negedge clk);
    rst = 1'b1;

    // Queue works again after reset.
    step(1'b1, 32'h500, 32'h2400_0500, 1'b0, 1'b0);
    pop_n(2);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_fetch_queue

// File: doc/fetch_queue.md
# fetch_queue

Decoupling instruction queue between the fetch stage and decode. It accepts (pc, inst) pairs from fetch through a valid/ready handshake and buffers up to DEPTH of them. It presents the oldest pair to decode in order. A pipeline flush from branch/jump resolution discards all buffered entries, and back-pressure from the queue is the fetch stage's stall source.

## Interface
- W, default 32 (`WORD_WIDTH`): width of pc and instruction words.
- DEPTH, default 4: entry count; power of two, at least 2.
- clk  in  1  pipeline clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset (asserted when 0); one clock; the polarity and synchronicity are fixed.
- flush  in  1  discard all entries and any same-cycle push/pop.
- in_valid  in  1  fetch presents a pair.
- in_ready  out  1  queue can accept; its inverse drives the fetch stage stall.
- in_pc  in  W  pc of the fetched instruction.
- in_inst  in  W  fetched instruction word.
- out_valid  out  1  head entry valid toward decode.
- out_ready  in  1  decode consumes head.
- out_pc  out  W  head pc.
- out_inst  out  W  head instruction.
- count  out  $clog2(DEPTH)+1  occupied entries, 0..DEPTH.

## Operation
- push = in_valid & in_ready & ~flush; pop = out_valid & out_ready & ~flush.
- Storage is a circular buffer with wr_ptr/rd_ptr of $clog2(DEPTH) bits that wrap modulo DEPTH naturally, plus count.
- push writes {in_pc, in_inst} at wr_ptr and increments wr_ptr. pop increments rd_ptr. count += push − pop.
- in_ready = (count != DEPTH). It does not depend on out_ready, so there is no combinational ready path. When full, a same-cycle pop does not enable a push.
- out_valid = (count != 0). out_pc/out_inst = entry[rd_ptr] when valid, `ZERO_WORD` otherwise.
- flush (synchronous): next state is count=0 and wr_ptr=rd_ptr=0. Pushes and pops in that cycle are ignored. flush takes priority over all other events.
- Simultaneous push and pop at 0<count<DEPTH: count unchanged, both pointers advance.
- Order is strictly FIFO; no entry is reordered or duplicated.

## Timing
- Reset (rst=0, asynchronous): count=0, pointers=0, out_valid=0, out_pc=out_inst=0, in_ready=1. Storage contents are don't-care.
- Reset asserted mid-operation clears state immediately, without a clock edge. The first push is accepted on the first posedge after rst=1.
- Latency without bypass: 1 cycle. A pair pushed at edge N is visible on out_* after edge N and can be popped at edge N+1.
- Throughput: 1 pair/cycle sustained when 0<count<DEPTH.
- A flush asserted at edge N gives out_valid=0 after edge N. fetch supplies the flush_addr instruction from edge N+1 onward.

## Configuration
- `FETCH_QUEUE_BYPASS_EN` defined: when count==0 and in_valid & ~flush, out_valid=1 and out_pc/out_inst = in_pc/in_inst combinationally.
  - If out_ready is also high, the pair is consumed that cycle and not stored (count stays 0).
  - Otherwise it is stored normally.
  - Latency is 0 cycles when empty.
- Undefined: no bypass; behaviour exactly as in Timing, with 1-cycle minimum latency.

## Structure
- `WORD_WIDTH` and `ZERO_WORD` come from the shared defines.v. A FETCH_QUEUE_DEPTH default constant is added there.
- One sub-module, fetch_queue_mem: a DEPTH×(2W) register array with one synchronous write port and one asynchronous read port. No reset is required on the array.
- Pointer, count and handshake logic stay in fetch_queue.

## Test plan
- Reset then single push of pc=0x0, inst=0x24010005 → after 1 edge out_valid=1, out_pc=0x0, out_inst=0x24010005, count=1. With bypass: visible the same cycle.
- Push 4 pairs pc=0x0..0xC with out_ready=0 → count=4, in_ready=0. A 5th push at pc=0x10 is not accepted. Then pop 4 → pcs appear in order 0x0, 0x4, 0x8, 0xC.
- Continuous push and pop over 10 pairs (pc 0x0..0x24) → count stays at 1, order preserved, and the pointers wrap without loss.
- At count=3 assert flush together with in_valid (pc=0x80) and out_ready → next cycle count=0, out_valid=0. The 0x80 pair is not stored, and the next push pc=0x100 is the head.
- Full with out_ready=1 and in_valid=1 for one edge → count=3, no push that edge.
- Drive rst=0 between edges at count=2 → outputs zero and count=0 before the next posedge.
